// File: rtl/vga_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_frame_ctrl_if
// Bundle of the frame controller's sync, enable, source-select and pixel
// signals. Clock and reset stay outside as plain module ports.
//
// Signals:
//   Vsync_i            sync counter vertical signal, high during active rows
//   en_i               video enable request (level)
//   cfg_req_i/sel_i    source-change request and requested source (1=pattern)
//   cfg_ack_o          pulse when the requested source takes effect
//   game_*_video_i     game renderer pixel
//   pat_*_video_i      test pattern pixel
//   *_video_o          pixel toward the porch stage
//   video_on_o         video currently enabled (ON or DRAIN)
//   frame_tick_o       one-cycle pulse per frame boundary
//   frame_cnt_o        wrapping frame boundary count
//
// Modports: master drives the inputs (renderer/test side), slave is the
// controller.
// ---------------------------------------------------------------------------
interface vga_frame_ctrl_if #(
    parameter int VIDEO_WIDTH     = 3,
    parameter int FRAME_CNT_WIDTH = 8
);
    logic                       Vsync_i;
    logic                       en_i;
    logic                       cfg_req_i;
    logic                       cfg_sel_i;
    logic                       cfg_ack_o;
    logic [VIDEO_WIDTH-1:0]     game_red_video_i;
    logic [VIDEO_WIDTH-1:0]     game_grn_video_i;
    logic [VIDEO_WIDTH-1:0]     game_blu_video_i;
    logic [VIDEO_WIDTH-1:0]     pat_red_video_i;
    logic [VIDEO_WIDTH-1:0]     pat_grn_video_i;
    logic [VIDEO_WIDTH-1:0]     pat_blu_video_i;
    logic [VIDEO_WIDTH-1:0]     red_video_o;
    logic [VIDEO_WIDTH-1:0]     grn_video_o;
    logic [VIDEO_WIDTH-1:0]     blu_video_o;
    logic                       video_on_o;
    logic                       frame_tick_o;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o;

    modport master (
        output Vsync_i, en_i, cfg_req_i, cfg_sel_i,
        output game_red_video_i, game_grn_video_i, game_blu_video_i,
        output pat_red_video_i, pat_grn_video_i, pat_blu_video_i,
        input  cfg_ack_o, red_video_o, grn_video_o, blu_video_o,
        input  video_on_o, frame_tick_o, frame_cnt_o
    );

    modport slave (
        input  Vsync_i, en_i, cfg_req_i, cfg_sel_i,
        input  game_red_video_i, game_grn_video_i, game_blu_video_i,
        input  pat_red_video_i, pat_grn_video_i, pat_blu_video_i,
        output cfg_ack_o, red_video_o, grn_video_o, blu_video_o,
        output video_on_o, frame_tick_o, frame_cnt_o
    );
endinterface

// File: rtl/vga_frame_ctrl.sv
// ---------------------------------------------------------------------------
// vga_frame_ctrl
// Frame-level controller ahead of the VGA porch stage. Video enable/disable
// and source changes are applied only at frame boundaries (falling edge of
// Vsync_i, i.e. start of vertical blank). After arming, BLANK_FRAMES
// boundaries are spent blanked so the monitor can lock.
//
// Ports:
//   clk_i    pixel clock
//   rst_n_i  asynchronous active-low reset
//   bus      vga_frame_ctrl_if.slave (sync, enable, config, pixels, status)
//
// State | meaning
// ------+----------------------------------------------------------------
// OFF   | video disabled, output blanked
// ARM   | enable seen, waiting for the next frame boundary
// WARMUP| blanked warm-up frames, r_blank_cnt boundaries remaining
// ON    | video enabled, selected source passed through
// DRAIN | disable requested, current frame finishes then OFF
// ---------------------------------------------------------------------------
module vga_frame_ctrl #(
    parameter int VIDEO_WIDTH     = 3,
    parameter int BLANK_FRAMES    = 2,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input logic             clk_i,
    input logic             rst_n_i,
    vga_frame_ctrl_if.slave bus
);

    localparam int BW = (BLANK_FRAMES < 2) ? 1 : $clog2(BLANK_FRAMES + 1);
    localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_FRAMES);
    localparam logic [BW-1:0] CNT_ONE    = BW'(1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_ARM    = 3'd1,
        S_WARMUP = 3'd2,
        S_ON     = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [BW-1:0]              r_blank_cnt;
    logic [BW-1:0]              w_blank_cnt_nxt;

    logic                       r_vs_q;
    logic                       r_req_q;
    logic                       r_pend;
    logic                       r_pend_sel;
    logic                       r_src_q;
    logic                       r_tick;
    logic                       r_ack;
    logic                       r_video_on;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
    logic [VIDEO_WIDTH-1:0]     r_red;
    logic [VIDEO_WIDTH-1:0]     r_grn;
    logic [VIDEO_WIDTH-1:0]     r_blu;

    logic                       w_fb;
    logic                       w_req_rise;
    logic                       w_on_nxt;
    logic [VIDEO_WIDTH-1:0]     w_red_sel;
    logic [VIDEO_WIDTH-1:0]     w_grn_sel;
    logic [VIDEO_WIDTH-1:0]     w_blu_sel;

    assign w_fb       = r_vs_q & ~bus.Vsync_i;
    assign w_req_rise = bus.cfg_req_i & ~r_req_q;
    assign w_on_nxt   = (w_state_nxt == S_ON) || (w_state_nxt == S_DRAIN);

    // Pixel mux uses the source in force before this edge; a source switch
    // at a boundary lands in vertical blank anyway.
    assign w_red_sel = r_src_q ? bus.pat_red_video_i : bus.game_red_video_i;
    assign w_grn_sel = r_src_q ? bus.pat_grn_video_i : bus.game_grn_video_i;
    assign w_blu_sel = r_src_q ? bus.pat_blu_video_i : bus.game_blu_video_i;

    // ------------------------------------------------------------------
    // Enable state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_OFF;
            r_blank_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_blank_cnt <= w_blank_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_blank_cnt_nxt = r_blank_cnt;
        case (r_state)
            S_OFF: begin
                if (bus.en_i) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                // Enable drop wins over a coincident boundary.
                if (!bus.en_i) begin
                    w_state_nxt = S_OFF;
                end else if (w_fb) begin
                    if (BLANK_FRAMES == 0) begin
                        w_state_nxt = S_ON;
                    end else begin
                        w_state_nxt     = S_WARMUP;
                        w_blank_cnt_nxt = BLANK_INIT;
                    end
                end
            end
            S_WARMUP: begin
                if (!bus.en_i) begin
                    w_state_nxt = S_OFF;
                end else if (w_fb) begin
                    w_blank_cnt_nxt = r_blank_cnt - CNT_ONE;
                    if (r_blank_cnt == CNT_ONE) begin
                        w_state_nxt = S_ON;
                    end
                end
            end
            S_ON: begin
                // A boundary coinciding with the drop is not consumed, so the
                // following frame still completes in DRAIN.
                if (!bus.en_i) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.en_i) begin
                    w_state_nxt = S_ON;
                end else if (w_fb) begin
                    w_state_nxt = S_OFF;
                end
            end
            default: begin
                w_state_nxt = S_OFF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sync edge detect, frame tick/counter, gated pixel output
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_vs_q      <= 1'b0;
            r_tick      <= 1'b0;
            r_frame_cnt <= '0;
            r_video_on  <= 1'b0;
            r_red       <= '0;
            r_grn       <= '0;
            r_blu       <= '0;
        end else begin
            r_vs_q     <= bus.Vsync_i;
            r_tick     <= w_fb;
            r_video_on <= w_on_nxt;
            if (w_fb) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_on_nxt) begin
                r_red <= w_red_sel;
                r_grn <= w_grn_sel;
                r_blu <= w_blu_sel;
            end else begin
                r_red <= '0;
                r_grn <= '0;
                r_blu <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Source-change handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_req_q    <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_sel <= 1'b0;
            r_src_q    <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_req_q <= bus.cfg_req_i;
            r_ack   <= w_fb & r_pend;
            // Only a request already pending before this edge is applied,
            // so one captured on a boundary edge waits a full frame.
            if (w_fb && r_pend) begin
                r_src_q <= r_pend_sel;
                r_pend  <= 1'b0;
            end else if (w_req_rise && !r_pend) begin
                r_pend     <= 1'b1;
                r_pend_sel <= bus.cfg_sel_i;
            end
        end
    end

    assign bus.red_video_o  = r_red;
    assign bus.grn_video_o  = r_grn;
    assign bus.blu_video_o  = r_blu;
    assign bus.video_on_o   = r_video_on;
    assign bus.frame_tick_o = r_tick;
    assign bus.frame_cnt_o  = r_frame_cnt;
    assign bus.cfg_ack_o    = r_ack;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
module tb_vga_frame_ctrl;

    localparam int VW  = 3;
    localparam int BF  = 2;
    localparam int FCW = 2;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;

    vga_frame_ctrl_if #(.VIDEO_WIDTH(VW), .FRAME_CNT_WIDTH(FCW)) bus ();

    vga_frame_ctrl #(
        .VIDEO_WIDTH    (VW),
        .BLANK_FRAMES   (BF),
        .FRAME_CNT_WIDTH(FCW)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic            on;
        logic            tick;
        logic            ack;
        logic [FCW-1:0]  cnt;
        logic [3*VW-1:0] pix;
    } obs_t;

    obs_t sb[$];

    int    checks = 0;
    int    errors = 0;
    int    cyc_n  = 0;
    string phase  = "reset";

    logic           en_d  = 1'b0;
    logic           req_d = 1'b0;
    logic           sel_d = 1'b0;
    logic           e_on  = 1'b0;
    logic           e_src = 1'b0;
    logic [FCW-1:0] e_cnt = '0;

    function automatic obs_t observe();
        obs_t o;
        o.on   = bus.video_on_o;
        o.tick = bus.frame_tick_o;
        o.ack  = bus.cfg_ack_o;
        o.cnt  = bus.frame_cnt_o;
        o.pix  = {bus.red_video_o, bus.grn_video_o, bus.blu_video_o};
        return o;
    endfunction

    task automatic check_next(input obs_t got);
        obs_t e;
        e = sb.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", phase, cyc_n, got, e);
        end
    endtask

    task automatic push_zero();
        obs_t e;
        e = '0;
        sb.push_back(e);
    endtask

    // One clock: drive inputs, push the expected post-edge outputs, then
    // sample 1 time unit after the edge and compare.
    task automatic cyc(input logic vs, input logic tick, input logic ack);
        obs_t           e;
        logic [VW-1:0]  gr, gg, gb, pr, pg, pb;
        gr = VW'($urandom); gg = VW'($urandom); gb = VW'($urandom);
        pr = VW'($urandom); pg = VW'($urandom); pb = VW'($urandom);
        bus.game_red_video_i = gr; bus.game_grn_video_i = gg; bus.game_blu_video_i = gb;
        bus.pat_red_video_i  = pr; bus.pat_grn_video_i  = pg; bus.pat_blu_video_i  = pb;
        bus.Vsync_i   = vs;
        bus.en_i      = en_d;
        bus.cfg_req_i = req_d;
        bus.cfg_sel_i = sel_d;
        if (tick) e_cnt = e_cnt + 1'b1;
        e.on   = e_on;
        e.tick = tick;
        e.ack  = ack;
        e.cnt  = e_cnt;
        e.pix  = !e_on ? '0 : (e_src ? {pr, pg, pb} : {gr, gg, gb});
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        cyc_n++;
        check_next(observe());
    endtask

    task automatic run(input int n, input logic vs);
        for (int i = 0; i < n; i++) cyc(vs, 1'b0, 1'b0);
    endtask

    task automatic fb(input logic ack);
        cyc(1'b0, 1'b1, ack);
    endtask

    initial begin
        bus.Vsync_i = 1'b0; bus.en_i = 1'b0; bus.cfg_req_i = 1'b0; bus.cfg_sel_i = 1'b0;
        bus.game_red_video_i = '0; bus.game_grn_video_i = '0; bus.game_blu_video_i = '0;
        bus.pat_red_video_i  = '0; bus.pat_grn_video_i  = '0; bus.pat_blu_video_i  = '0;

        // Reset state
        #12;
        push_zero();
        check_next(observe());
        rst_n_i = 1'b1;

        // Idle frame: counter and tick run while OFF
        phase = "idle";
        run(3, 1'b1);
        fb(1'b0);
        run(2, 1'b0);

        // Enable mid-frame, two warm-up frames
        phase = "enable";
        run(2, 1'b1);
        en_d = 1'b1;
        run(3, 1'b1);
        fb(1'b0);                 // fb1: ARM -> WARMUP
        run(2, 1'b0);
        run(4, 1'b1);
        fb(1'b0);                 // fb2: WARMUP
        run(2, 1'b0);
        run(4, 1'b1);
        e_on = 1'b1;
        fb(1'b0);                 // fb3: -> ON, counter wraps to 0
        run(2, 1'b0);
        run(3, 1'b1);

        // Source change, second rising edge ignored while pending
        phase = "cfg";
        req_d = 1'b1; sel_d = 1'b1;
        run(1, 1'b1);
        req_d = 1'b0;
        run(1, 1'b1);
        req_d = 1'b1; sel_d = 1'b0;
        run(1, 1'b1);
        req_d = 1'b0;
        run(1, 1'b1);
        fb(1'b1);
        e_src = 1'b1;
        run(2, 1'b0);
        run(3, 1'b1);

        // Request captured on the boundary edge waits one frame
        phase = "cfg_on_fb";
        req_d = 1'b1; sel_d = 1'b0;
        fb(1'b0);
        req_d = 1'b0;
        run(2, 1'b0);
        run(3, 1'b1);
        fb(1'b1);
        e_src = 1'b0;
        run(2, 1'b0);

        // Disable mid-frame, cancel, drop on a boundary, then drain to OFF
        phase = "disable";
        run(2, 1'b1);
        en_d = 1'b0;
        run(3, 1'b1);
        en_d = 1'b1;
        run(2, 1'b1);
        fb(1'b0);
        run(2, 1'b0);
        run(3, 1'b1);
        en_d = 1'b0;
        fb(1'b0);                 // ON -> DRAIN, boundary not consumed
        run(2, 1'b0);
        run(3, 1'b1);
        e_on = 1'b0;
        fb(1'b0);                 // DRAIN -> OFF
        run(2, 1'b0);

        // Abort warm-up on the boundary that would otherwise enter ON
        phase = "abort";
        en_d = 1'b1;
        run(3, 1'b1);
        fb(1'b0);
        run(2, 1'b0);
        run(3, 1'b1);
        fb(1'b0);
        run(2, 1'b0);
        run(3, 1'b1);
        en_d = 1'b0;
        fb(1'b0);
        run(2, 1'b0);
        run(2, 1'b1);

        // Back to ON, then reset with a request pending
        phase = "reset_mid";
        en_d = 1'b1;
        run(1, 1'b1);
        fb(1'b0);
        run(2, 1'b0);
        run(3, 1'b1);
        fb(1'b0);
        run(2, 1'b0);
        run(3, 1'b1);
        e_on = 1'b1;
        fb(1'b0);
        run(2, 1'b0);
        run(2, 1'b1);
        req_d = 1'b1; sel_d = 1'b1;
        run(1, 1'b1);
        req_d = 1'b0;
        run(1, 1'b1);
        #3;
        rst_n_i = 1'b0;
        en_d = 1'b0; e_on = 1'b0; e_src = 1'b0; e_cnt = '0;
        #1;
        push_zero();
        check_next(observe());
        bus.Vsync_i = 1'b1;
        @(posedge clk_i);
        #1;
        push_zero();
        check_next(observe());
        rst_n_i = 1'b1;

        phase = "after_reset";
        run(2, 1'b0);
        run(3, 1'b1);
        fb(1'b0);
        run(3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_ctrl.md
# vga_frame_ctrl

Frame-level controller in front of the VGA porch stage. It sequences video enable and disable so that both happen only at frame boundaries, and blanks a programmable number of warm-up frames so the monitor can lock. It selects between the game renderer and a test-pattern source, applying source changes only at a frame boundary through a request/acknowledge handshake. It also emits a per-frame tick and a frame counter for game logic.

## Interface
- VIDEO_WIDTH, 3, bits per colour channel
- BLANK_FRAMES, 2, frame boundaries spent blanked after arming (0 allowed)
- FRAME_CNT_WIDTH, 8, width of frame counter

- clk_i  in  1  pixel clock (25 MHz)
- rst_n_i  in  1  reset, asynchronous, active-low
- Vsync_i  in  1  from sync counter; high during active rows
- en_i  in  1  level; video enable request
- cfg_req_i  in  1  source-change request; rising edge captured
- cfg_sel_i  in  1  requested source: 0 = game, 1 = pattern
- cfg_ack_o  out  1  one-cycle pulse when the requested source takes effect
- game_red/grn/blu_video_i  in  VIDEO_WIDTH each  game renderer pixel
- pat_red/grn/blu_video_i  in  VIDEO_WIDTH each  test pattern pixel
- red/grn/blu_video_o  out  VIDEO_WIDTH each  pixel to porch stage
- video_on_o  out  1  high in ON or DRAIN
- frame_tick_o  out  1  one-cycle pulse per frame boundary
- frame_cnt_o  out  FRAME_CNT_WIDTH  frame boundaries since reset, wraps

## Operation
- vs_q <= Vsync_i each cycle.
- Frame boundary (fb) occurs at an edge where vs_q=1 and Vsync_i=0 (start of vertical blank).
- frame_cnt_o increments by 1 at every fb, modulo 2^FRAME_CNT_WIDTH, in every state.
- frame_tick_o is registered: high for exactly the cycle after each fb edge.
- State machine (OFF, ARM, WARMUP, ON, DRAIN):
  - OFF: en_i=1 -> ARM.
  - ARM: en_i=0 -> OFF. On fb: -> ON if BLANK_FRAMES=0, else -> WARMUP with blank_cnt=BLANK_FRAMES.
  - WARMUP: en_i=0 -> OFF. On fb: blank_cnt decrements; the fb seen with blank_cnt=1 -> ON.
  - ON: en_i=0 -> DRAIN.
  - DRAIN: en_i=1 -> ON (cancel). Otherwise on fb -> OFF.
- en_i takes priority over fb in ARM and WARMUP. In ON, an en_i drop coinciding with fb gives DRAIN; that fb is not consumed.
- Pixel output, registered: in ON or DRAIN (the state after the edge), the source selected by src_q; otherwise all zero.
- Config handshake:
  - req_q <= cfg_req_i.
  - A rising edge (cfg_req_i=1, req_q=0) with no pending request latches pend_sel<=cfg_sel_i and sets pend.
  - Rising edges while pend=1 are ignored.
  - At the next fb with pend=1: src_q<=pend_sel, pend cleared, cfg_ack_o pulses the following cycle.
  - A request captured on the same edge as an fb is applied at the following fb, not this one.
  - A new request needs cfg_req_i low at least one cycle.
- Source switching is independent of the enable state.

## Timing
- Reset (async assert, sync deassert in system) forces:
  - state OFF, vs_q=0, req_q=0, pend=0, src_q=0 (game), blank_cnt=0
  - all video outputs 0; video_on_o, frame_tick_o, cfg_ack_o = 0; frame_cnt_o=0
- No fb can occur in the first cycle after reset, since vs_q=0.
- Reset mid-operation: output blanks immediately; any pending config is discarded with no ack.
- Pixel latency: input to output is 1 cycle.
- video_on_o and the pixel gating change on the same edge as the state.
- ON entry occurs at an fb edge, so the first non-zero pixel is in vertical blank; the porch stage masks it. Enabled video therefore always starts at a frame's first active row, and DRAIN guarantees the last frame completes.
- cfg_ack_o is coincident with frame_tick_o.

## Test plan
- Enable and warm-up:
  - Stimulus: BLANK_FRAMES=2; assert en_i mid-frame.
  - Required: ARM until fb1, WARMUP across fb2. ON after fb3. Output 0 until fb3+1 cycle, then game pixel (e.g. 3'b101/3'b011/3'b110) with 1-cycle latency.
- Disable and cancel:
  - Stimulus: drop en_i mid-frame in ON.
  - Required: pixels continue until next fb, then 0 and video_on_o=0.
  - Stimulus: re-raise en_i before fb.
  - Required: stays ON, no blank.
- Abort warm-up:
  - Stimulus: drop en_i during WARMUP coincident with fb.
  - Required: OFF; output stays 0.
- Config handshake:
  - Stimulus: cfg_req_i rising with cfg_sel_i=1 mid-frame, then a second rising edge before fb.
  - Required: at fb, src_q=1 and one cfg_ack_o pulse; second request ignored.
  - Stimulus: request on the fb edge itself.
  - Required: applied one frame later.
- Frame counter:
  - Stimulus: FRAME_CNT_WIDTH=2; run 5 frames.
  - Required: frame_cnt_o 1,2,3,0,1 and 5 frame_tick_o pulses, each 1 cycle wide.
- Reset mid-frame:
  - Stimulus: assert rst_n_i low in ON with a request pending.
  - Required: all outputs 0 immediately, no ack; after release, Vsync_i low then high-to-low yields exactly one fb.
